// File: rtl/halut_result_collector.sv
// HALUT result collector: per-lane result FIFOs, round-robin serializer onto a
// single valid/ready stream, completed-row counter and sticky overflow flag.
module halut_result_collector #(
  parameter int unsigned DecUnitsX   = 4,
  parameter int unsigned M           = 32,
  parameter int unsigned MAddrWidth  = $clog2(M),
  parameter int unsigned ResultWidth = 32,
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned RowCntWidth = 16,
  localparam int unsigned LaneWidth  = $clog2(DecUnitsX)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic [DecUnitsX*ResultWidth-1:0] result_i,
  input  logic [DecUnitsX-1:0]             valid_i,
  input  logic [DecUnitsX*MAddrWidth-1:0]  m_addr_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [ResultWidth-1:0]           out_result_o,
  output logic [MAddrWidth-1:0]            out_m_addr_o,
  output logic [LaneWidth-1:0]             out_lane_o,
  output logic                             row_done_o,
  output logic [RowCntWidth-1:0]           row_count_o,
  output logic                             overflow_o
);

  localparam int unsigned AddrW   = $clog2(FifoDepth);
  localparam int unsigned PtrW    = AddrW + 1;
  localparam int unsigned EntryW  = ResultWidth + MAddrWidth;
  localparam int unsigned RowPosW = (M > 1) ? $clog2(M) : 1;

  logic [EntryW-1:0]      mem_q [DecUnitsX][FifoDepth];
  logic [PtrW-1:0]        wr_ptr_q [DecUnitsX];
  logic [PtrW-1:0]        wr_ptr_d [DecUnitsX];
  logic [PtrW-1:0]        rd_ptr_q [DecUnitsX];
  logic [PtrW-1:0]        rd_ptr_d [DecUnitsX];
  logic [DecUnitsX-1:0]   empty_c, full_c, push_c, pop_c;
  logic [LaneWidth-1:0]   rr_ptr_q, rr_ptr_d, sel_c, cand_c;
  logic                   found_c, load_c, hs_c;
  logic                   out_valid_q, out_valid_d;
  logic [ResultWidth-1:0] out_result_q, out_result_d;
  logic [MAddrWidth-1:0]  out_m_addr_q, out_m_addr_d;
  logic [LaneWidth-1:0]   out_lane_q, out_lane_d;
  logic [RowPosW-1:0]     row_pos_q, row_pos_d;
  logic                   row_done_q, row_done_d;
  logic [RowCntWidth-1:0] row_count_q, row_count_d;
  logic                   overflow_q, overflow_d;

  // Per-lane FIFO occupancy from wrap-bit pointers.
  always_comb begin
    empty_c = '0;
    full_c  = '0;
    for (int x = 0; x < int'(DecUnitsX); x++) begin
      empty_c[x] = (wr_ptr_q[x] == rd_ptr_q[x]);
      full_c[x]  = ((wr_ptr_q[x] - rd_ptr_q[x]) == PtrW'(FifoDepth));
    end
  end

  // Round-robin pick: first non-empty lane at or after the pointer.
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    cand_c  = '0;
    for (int unsigned i = 0; i < DecUnitsX; i++) begin
      cand_c = LaneWidth'((32'(rr_ptr_q) + i) % DecUnitsX);
      if (!found_c && !empty_c[cand_c]) begin
        found_c = 1'b1;
        sel_c   = cand_c;
      end
    end
  end

  // Handshake, pop and push decisions; a full FIFO popped this cycle still accepts.
  always_comb begin
    load_c = !out_valid_q || out_ready_i;
    hs_c   = out_valid_q && out_ready_i;
    pop_c  = '0;
    if (load_c && found_c) pop_c[sel_c] = 1'b1;
    push_c = valid_i & (~full_c | pop_c);
  end

  // Next-state for pointers, output register, row tracking and overflow.
  always_comb begin
    for (int x = 0; x < int'(DecUnitsX); x++) begin
      wr_ptr_d[x] = wr_ptr_q[x] + PtrW'(push_c[x]);
      rd_ptr_d[x] = rd_ptr_q[x] + PtrW'(pop_c[x]);
    end
    rr_ptr_d     = rr_ptr_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_m_addr_d = out_m_addr_q;
    out_lane_d   = out_lane_q;
    row_pos_d    = row_pos_q;
    row_done_d   = 1'b0;
    row_count_d  = row_count_q;
    overflow_d   = overflow_q | (|(valid_i & full_c & ~pop_c));

    if (load_c) begin
      if (found_c) begin
        out_valid_d                  = 1'b1;
        {out_result_d, out_m_addr_d} = mem_q[sel_c][rd_ptr_q[sel_c][AddrW-1:0]];
        out_lane_d                   = sel_c;
        rr_ptr_d = (sel_c == LaneWidth'(DecUnitsX - 1)) ? '0 : sel_c + LaneWidth'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end

    if (hs_c) begin
      if (row_pos_q == RowPosW'(M - 1)) begin
        row_pos_d   = '0;
        row_count_d = row_count_q + RowCntWidth'(1);
        row_done_d  = 1'b1;
      end else begin
        row_pos_d = row_pos_q + RowPosW'(1);
      end
    end
  end

  // State registers; reset and clear flush everything.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int x = 0; x < int'(DecUnitsX); x++) begin
        wr_ptr_q[x] <= '0;
        rd_ptr_q[x] <= '0;
      end
      rr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_m_addr_q <= '0;
      out_lane_q   <= '0;
      row_pos_q    <= '0;
      row_done_q   <= 1'b0;
      row_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      for (int x = 0; x < int'(DecUnitsX); x++) begin
        wr_ptr_q[x] <= wr_ptr_d[x];
        rd_ptr_q[x] <= rd_ptr_d[x];
      end
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_m_addr_q <= out_m_addr_d;
      out_lane_q   <= out_lane_d;
      row_pos_q    <= row_pos_d;
      row_done_q   <= row_done_d;
      row_count_q  <= row_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk_i) begin
    for (int x = 0; x < int'(DecUnitsX); x++) begin
      if (push_c[x]) begin
        mem_q[x][wr_ptr_q[x][AddrW-1:0]] <= {result_i[x*ResultWidth +: ResultWidth],
                                             m_addr_i[x*MAddrWidth +: MAddrWidth]};
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign out_m_addr_o = out_m_addr_q;
  assign out_lane_o   = out_lane_q;
  assign row_done_o   = row_done_q;
  assign row_count_o  = row_count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: doc/halut_result_collector.md
Name: halut_result_collector

Overview:
Sink-side companion to the HALUT matmul top. It receives the fire-and-forget per-decoder-group result streams (result, valid, m_addr for each of DecUnitsX groups) and buffers each group in a small FIFO. A round-robin arbiter serializes the buffered results onto one valid/ready output stream for writeback. It also counts completed output rows (M results each) and flags any result lost to FIFO overflow.

Parameters:
- DecUnitsX, 4, number of decoder groups / input lanes
- M, 32, results per output row
- MAddrWidth, $clog2(M), width of the column address
- ResultWidth, 32, result word width (FP32 or INT32, opaque here)
- FifoDepth, 4, entries per lane FIFO (power of two, >=2)
- RowCntWidth, 16, width of the row counter

Ports:
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous flush of FIFOs, output register, counters and sticky flag
- result_i  in  ResultWidth x DecUnitsX  per-lane result word
- valid_i  in  1 x DecUnitsX  per-lane single-cycle result strobe (no backpressure)
- m_addr_i  in  MAddrWidth x DecUnitsX  per-lane column address
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  downstream accept
- out_result_o  out  ResultWidth  output result
- out_m_addr_o  out  MAddrWidth  output column address
- out_lane_o  out  $clog2(DecUnitsX)  source lane of the output word
- row_done_o  out  1  one-cycle pulse after the M-th accepted word of a row
- row_count_o  out  RowCntWidth  completed rows, wraps modulo 2^RowCntWidth
- overflow_o  out  1  sticky: a strobe arrived while its lane FIFO was full

Behaviour:
- Reset (rst_i=1 at an edge): all FIFOs empty, arbiter pointer=0, out_valid_o=0, out_result_o=0, out_m_addr_o=0, out_lane_o=0, row_done_o=0, row_count_o=0, overflow_o=0. Reset overrides every other input, including mid-transfer.
- clear_i has the same effect as reset. It has priority over valid_i and any handshake in the same cycle.
- Lane push: valid_i[x]=1 writes {result_i[x], m_addr_i[x]} into FIFO x at the edge.
  - If FIFO x is full and not popped that cycle, the word is dropped and overflow_o is set, then held until reset or clear.
  - A push and a pop on the same full FIFO in the same cycle is accepted without overflow.
  - Pushes on all lanes in one cycle are all accepted.
- Output register, no bypass: it loads when out_valid_o=0 or (out_valid_o & out_ready_i).
  - Load source: the first non-empty FIFO at or after the arbiter pointer, searching upward modulo DecUnitsX.
  - On load: pop that FIFO, set out_valid_o=1, set out_lane_o to the lane, and set the pointer to lane+1 modulo DecUnitsX.
  - If no FIFO is non-empty, out_valid_o becomes 0 after a handshake. The pointer is unchanged.
- Latency: a strobe at cycle t, with an idle output and empty FIFOs, gives out_valid_o=1 in cycle t+2.
- Back-to-back: with out_ready_i held at 1, one word per cycle.
- Stability: while out_valid_o=1 and out_ready_i=0, out_result_o, out_m_addr_o and out_lane_o hold stable.
- Capacity per lane under stall is FifoDepth+1: FIFO plus the output register.
- Row tracking: an internal counter counts handshakes (out_valid_o & out_ready_i), range 0..M-1.
  - On the M-th handshake the counter returns to 0 and row_count_o increments.
  - row_done_o=1 for exactly the following cycle.
- The block does not check m_addr ordering or coverage; it passes values through unchanged.

Test Plan:
- Single word: reset, then valid_i[2]=1 with result=0x3F800000 and m_addr=9 at cycle 5, out_ready_i=1. Expect out_valid_o=1 only in cycle 7, with out_result_o=0x3F800000, out_m_addr_o=9, out_lane_o=2.
- Fan-in: all 4 lanes strobe in one cycle with results 0xA0..0xA3, out_ready_i=1. Expect outputs on 4 consecutive cycles in lane order 0,1,2,3 and a final pointer of 0. Then strobe lanes 1 and 3; expect order 1 then 3.
- Backpressure: out_ready_i=0, 3 strobes on lane 0. Expect the first word held stable for 10 cycles. Raise ready; expect the 3 words in push order on consecutive cycles.
- Overflow: out_ready_i=0, 6 strobes on lane 1 over 6 cycles. Expect overflow_o=1 after the 6th, with the first 5 words delivered once ready rises. Then clear_i: expect overflow_o=0 and out_valid_o=0 on the next cycle.
- Row completion, M=32: 8 rounds of all-lane strobes with out_ready_i=1. Expect row_done_o pulsing once, the cycle after the 32nd handshake, and row_count_o=1. Repeat 2^16 rows in a fast-forward model; expect row_count_o wrapping to 0.
- Reset mid-operation: rst_i for 1 cycle while 3 FIFOs are non-empty and out_valid_o=1. Expect all outputs at reset values the next cycle, and no stale word emitted afterwards.
